// File: rtl/twiddle_gen.sv
// FFT twiddle-factor generator: quarter-wave sine table, quadrant folding, and a
// two-stage valid/ready pipeline that carries an opaque tag with each request.
module twiddle_gen #(
   parameter  int N     = 8,
   parameter  int WIDTH = 16,
   parameter  int TAG_W = 4,
   localparam int LOG2N = $clog2(N),
   localparam int SHW   = $clog2(LOG2N + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LOG2N-1:0]        k_i,
   input  logic [SHW-1:0]          shift_i,
   input  logic                    inv_i,
   input  logic [TAG_W-1:0]        tag_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] re_o,
   output logic signed [WIDTH-1:0] im_o,
   output logic [TAG_W-1:0]        tag_o
);

   localparam int                      QW     = LOG2N - 2;
   localparam logic [LOG2N-2:0]        QTR    = (LOG2N - 1)'(N / 4);
   localparam logic [SHW-1:0]          SH_MAX = SHW'(LOG2N);
   localparam logic signed [WIDTH-1:0] MAXP   = {1'b0, {(WIDTH - 1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MINN   = {1'b1, {(WIDTH - 1){1'b0}}};

   // Elaboration-time sine via Taylor series; rounds half away from zero, S[N/4] saturates.
   function automatic logic signed [WIDTH-1:0] sin_q(input int i);
      real    x, term, sum, t;
      longint l;
      x    = 2.0 * 3.14159265358979323846 * real'(i) / real'(N);
      term = x;
      sum  = 0.0;
      for (int n = 0; n < 24; n++) begin
         sum  = sum + term;
         term = -term * x * x / real'((2 * n + 2) * (2 * n + 3));
      end
      t = sum * (2.0 ** (WIDTH - 1)) + 0.5;
      l = longint'(t);
      if (real'(l) > t) l = l - 1;
      if (l > longint'(MAXP)) l = longint'(MAXP);
      return WIDTH'(l);
   endfunction

   function automatic logic signed [WIDTH-1:0] neg(input logic signed [WIDTH-1:0] x);
      return (x == MAXP) ? MINN : -x;
   endfunction

   logic signed [WIDTH-1:0] w_tbl [0:N/4];
   for (genvar gi = 0; gi <= N / 4; gi++) begin : g_tbl
      assign w_tbl[gi] = sin_q(gi);
   end

   logic                    w_en;
   logic [LOG2N-1:0]        w_k;
   logic signed [WIDTH-1:0] w_a, w_b, w_cos, w_sin, w_nsin, w_im;

   logic                    r_vld1, r_vld2;
   logic [QW-1:0]           r_off;
   logic [LOG2N-2:0]        r_offc;
   logic [1:0]              r_q;
   logic                    r_inv;
   logic [TAG_W-1:0]        r_tag1, r_tag2;
   logic signed [WIDTH-1:0] r_re, r_im;

   assign w_en     = !r_vld2 || out_ready;
   assign in_ready = w_en && !rst;
   assign w_k      = (shift_i >= SH_MAX) ? '0 : (k_i << shift_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld1 <= 1'b0;
         r_off  <= '0;
         r_offc <= '0;
         r_q    <= '0;
         r_inv  <= 1'b0;
         r_tag1 <= '0;
      end else if (w_en) begin
         r_vld1 <= in_valid;
         r_off  <= w_k[QW-1:0];
         r_offc <= QTR - {1'b0, w_k[QW-1:0]};
         r_q    <= w_k[LOG2N-1:LOG2N-2];
         r_inv  <= inv_i;
         r_tag1 <= tag_i;
      end
   end

   // nsin carries -sin directly so the forward-transform imaginary part never
   // double-negates the -1 encoding.
   always_comb begin
      w_a    = w_tbl[{1'b0, r_off}];
      w_b    = w_tbl[r_offc];
      w_cos  = w_b;
      w_sin  = w_a;
      w_nsin = neg(w_a);
      case (r_q)
         2'd1: begin
            w_cos  = neg(w_a);
            w_sin  = w_b;
            w_nsin = neg(w_b);
         end
         2'd2: begin
            w_cos  = neg(w_b);
            w_sin  = neg(w_a);
            w_nsin = w_a;
         end
         2'd3: begin
            w_cos  = w_a;
            w_sin  = neg(w_b);
            w_nsin = w_b;
         end
         default: ;
      endcase
      w_im = r_inv ? w_sin : w_nsin;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld2 <= 1'b0;
         r_re   <= '0;
         r_im   <= '0;
         r_tag2 <= '0;
      end else if (w_en) begin
         r_vld2 <= r_vld1;
         r_re   <= w_cos;
         r_im   <= w_im;
         r_tag2 <= r_tag1;
      end
   end

   assign out_valid = r_vld2;
   assign re_o      = r_re;
   assign im_o      = r_im;
   assign tag_o     = r_tag2;

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen: N=8/W=16 and N=1024/W=18 instances checked against a
// trig-based reference model and fixed vectors.
module tb_twiddle_gen;

   localparam real PI = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // N=8, WIDTH=16
   logic                a_vld, a_irdy, a_inv, a_ov, a_ordy;
   logic [2:0]          a_k;
   logic [1:0]          a_sh;
   logic [3:0]          a_tag, a_tago;
   logic signed [15:0]  a_re, a_im;

   // N=1024, WIDTH=18
   logic                b_vld, b_irdy, b_inv, b_ov, b_ordy;
   logic [9:0]          b_k;
   logic [3:0]          b_sh;
   logic [3:0]          b_tag, b_tago;
   logic signed [17:0]  b_re, b_im;

   twiddle_gen #(.N(8), .WIDTH(16), .TAG_W(4)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_vld), .in_ready(a_irdy), .k_i(a_k),
      .shift_i(a_sh), .inv_i(a_inv), .tag_i(a_tag), .out_valid(a_ov),
      .out_ready(a_ordy), .re_o(a_re), .im_o(a_im), .tag_o(a_tago));

   twiddle_gen #(.N(1024), .WIDTH(18), .TAG_W(4)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_vld), .in_ready(b_irdy), .k_i(b_k),
      .shift_i(b_sh), .inv_i(b_inv), .tag_i(b_tag), .out_valid(b_ov),
      .out_ready(b_ordy), .re_o(b_re), .im_o(b_im), .tag_o(b_tago));

   function automatic longint qnt(input real x, input int w);
      real    s;
      longint r, mx;
      s  = x * (2.0 ** (w - 1));
      mx = longint'(1) << (w - 1);
      r  = (s >= 0.0) ? longint'($floor(s + 0.5)) : -longint'($floor(-s + 0.5));
      if (r > mx - 1) r = mx - 1;
      if (r < -mx) r = -mx;
      return r;
   endfunction

   // W_N^k = cos - j sin, conjugated for inverse; effective k from shift rule.
   task automatic model(input int n, input int w, input int k, input int sh, input bit inv,
                        output longint re, output longint im);
      int  lg, ke;
      real ang;
      lg  = $clog2(n);
      ke  = (sh >= lg) ? 0 : ((k << sh) % n);
      ang = 2.0 * PI * real'(ke) / real'(n);
      re  = qnt($cos(ang), w);
      im  = qnt(inv ? $sin(ang) : -$sin(ang), w);
   endtask

   task automatic drv_a(input bit v, input int k, input int sh, input bit inv,
                        input int tag, input bit ordy, input bit r);
      @(posedge clk);
      #1;
      a_vld = v; a_k = 3'(k); a_sh = 2'(sh); a_inv = inv; a_tag = 4'(tag);
      a_ordy = ordy; rst = r;
      #1;
   endtask

   task automatic drv_b(input bit v, input int k, input int sh, input bit inv, input int tag);
      @(posedge clk);
      #1;
      b_vld = v; b_k = 10'(k); b_sh = 4'(sh); b_inv = inv; b_tag = 4'(tag); b_ordy = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      drv_a(0, 0, 0, 0, 0, 1, 1);
      drv_a(0, 0, 0, 0, 0, 1, 1);
      n_chk++;
      if ({a_ov, a_re, a_im, a_tago, a_irdy} !== '0 || {b_ov, b_re, b_im, b_tago, b_irdy} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: a ov=%b re=%0d im=%0d tag=%0d rdy=%b b ov=%b rdy=%b, want all 0",
                  a_ov, a_re, a_im, a_tago, a_irdy, b_ov, b_irdy);
      end
      drv_a(0, 0, 0, 0, 0, 1, 0);
      n_chk++;
      if (a_irdy !== 1'b1 || a_ov !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", a_irdy, a_ov);
      end
   endtask

   task automatic test_sweep();
      longint ere [8] = '{32767, 23170, 0, -23170, -32768, -23170, 0, 23170};
      longint eim [8] = '{0, -23170, -32768, -23170, 0, 23170, 32767, 23170};
      for (int j = 0; j < 10; j++) begin
         drv_a(j < 8, j % 8, 0, 0, j + 3, 1, 0);
         if (j == 1) begin
            n_chk++;
            if (a_ov !== 1'b0) begin
               n_fail++;
               $display("FAIL sweep_latency: out_valid=%b one cycle after accept, want 0", a_ov);
            end
         end
         if (j >= 2) begin
            n_chk++;
            if (a_ov !== 1'b1 || longint'(a_re) != ere[j-2] || longint'(a_im) != eim[j-2]
                || a_tago !== 4'(j + 1)) begin
               n_fail++;
               $display("FAIL sweep_k%0d: ov=%b re=%0d im=%0d tag=%0d, want 1 %0d %0d %0d",
                        j - 2, a_ov, a_re, a_im, a_tago, ere[j-2], eim[j-2], j + 1);
            end
         end
      end
   endtask

   task automatic test_inverse();
      int     ks  [3] = '{2, 6, 1};
      longint ere [3] = '{0, 0, 23170};
      longint eim [3] = '{32767, -32768, 23170};
      for (int j = 0; j < 5; j++) begin
         drv_a(j < 3, (j < 3) ? ks[j] : 0, 0, 1, j, 1, 0);
         if (j >= 2) begin
            n_chk++;
            if (a_ov !== 1'b1 || longint'(a_re) != ere[j-2] || longint'(a_im) != eim[j-2]
                || a_tago !== 4'(j - 2)) begin
               n_fail++;
               $display("FAIL inverse_k%0d: ov=%b re=%0d im=%0d tag=%0d, want 1 %0d %0d %0d",
                        ks[j-2], a_ov, a_re, a_im, a_tago, ere[j-2], eim[j-2], j - 2);
            end
         end
      end
   endtask

   task automatic test_shift();
      int     ks  [3] = '{1, 3, 5};
      int     ss  [3] = '{2, 2, 3};
      longint ere [3] = '{-32768, -32768, 32767};
      for (int j = 0; j < 5; j++) begin
         drv_a(j < 3, (j < 3) ? ks[j] : 0, (j < 3) ? ss[j] : 0, 0, 8 + j, 1, 0);
         if (j >= 2) begin
            n_chk++;
            if (a_ov !== 1'b1 || longint'(a_re) != ere[j-2] || a_im !== 16'sd0
                || a_tago !== 4'(6 + j)) begin
               n_fail++;
               $display("FAIL shift_k%0d_s%0d: ov=%b re=%0d im=%0d tag=%0d, want 1 %0d 0 %0d",
                        ks[j-2], ss[j-2], a_ov, a_re, a_im, a_tago, ere[j-2], 6 + j);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int     pat [6] = '{1, 0, 0, 1, 0, 1};
      longint qre [$];
      longint qim [$];
      int     qtag [$];
      longint mre, mim;
      int     sent = 0, got = 0, ck, csh, ctag;
      bit     cinv, ordy, stall_prev = 1'b0;
      logic [36:0] prev = '0;
      ck = $urandom_range(0, 7); csh = $urandom_range(0, 3); cinv = 1'($urandom_range(0, 1));
      ctag = $urandom_range(0, 15);
      for (int c = 0; c < 200 && got < 6; c++) begin
         ordy = (c < 6) ? 1'(pat[c]) : 1'($urandom_range(0, 1));
         drv_a(sent < 6, ck, csh, cinv, ctag, ordy, 0);
         if (stall_prev) begin
            n_chk++;
            if ({a_ov, a_re, a_im, a_tago} !== prev) begin
               n_fail++;
               $display("FAIL bp_stable: outputs %h changed during stall, want %h",
                        {a_ov, a_re, a_im, a_tago}, prev);
            end
         end
         if (a_ov && !a_ordy) begin
            n_chk++;
            if (a_irdy !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_in_ready: in_ready=%b while stalled, want 0", a_irdy);
            end
         end
         if (a_ov && a_ordy) begin
            n_chk++;
            if (qtag.size() == 0) begin
               n_fail++;
               $display("FAIL bp_extra: unexpected result tag=%0d, want none", a_tago);
            end else begin
               mre = qre.pop_front(); mim = qim.pop_front();
               if (longint'(a_re) != mre || longint'(a_im) != mim || a_tago !== 4'(qtag[0])) begin
                  n_fail++;
                  $display("FAIL bp_result%0d: re=%0d im=%0d tag=%0d, want %0d %0d %0d",
                           got, a_re, a_im, a_tago, mre, mim, qtag[0]);
               end
               void'(qtag.pop_front());
            end
            got++;
         end
         if (a_vld && a_irdy) begin
            model(8, 16, ck, csh, cinv, mre, mim);
            qre.push_back(mre); qim.push_back(mim); qtag.push_back(ctag);
            sent++;
            ck = $urandom_range(0, 7); csh = $urandom_range(0, 3);
            cinv = 1'($urandom_range(0, 1)); ctag = (ctag + 1 + $urandom_range(0, 2)) % 16;
         end
         stall_prev = a_ov && !a_ordy;
         prev = {a_ov, a_re, a_im, a_tago};
      end
      n_chk++;
      if (got != 6 || sent != 6 || qtag.size() != 0) begin
         n_fail++;
         $display("FAIL bp_count: sent=%0d delivered=%0d pending=%0d, want 6 6 0",
                  sent, got, qtag.size());
      end
      drv_a(0, 0, 0, 0, 0, 1, 0);
      drv_a(0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_reset_mid();
      drv_a(1, 1, 0, 0, 9, 1, 0);
      drv_a(1, 2, 0, 0, 10, 1, 0);
      drv_a(0, 0, 0, 0, 0, 0, 1);
      n_chk++;
      if (a_irdy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_in_ready: in_ready=%b during reset, want 0", a_irdy);
      end
      drv_a(1, 5, 0, 0, 11, 1, 0);
      n_chk++;
      if ({a_ov, a_re, a_im, a_tago} !== '0 || a_irdy !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_clear: ov=%b re=%0d im=%0d tag=%0d rdy=%b, want 0 0 0 0 1",
                  a_ov, a_re, a_im, a_tago, a_irdy);
      end
      for (int j = 0; j < 5; j++) begin
         drv_a(0, 0, 0, 0, 0, 1, 0);
         if (a_ov && (a_tago == 4'd9 || a_tago == 4'd10)) begin
            n_fail++;
            $display("FAIL rstmid_dropped: tag=%0d presented after reset, want never", a_tago);
         end
         if (j == 1) begin
            n_chk++;
            if (a_ov !== 1'b1 || a_re !== -16'sd23170 || a_im !== 16'sd23170 || a_tago !== 4'd11) begin
               n_fail++;
               $display("FAIL rstmid_next: ov=%b re=%0d im=%0d tag=%0d, want 1 -23170 23170 11",
                        a_ov, a_re, a_im, a_tago);
            end
         end else begin
            n_chk++;
            if (a_ov !== 1'b0) begin
               n_fail++;
               $display("FAIL rstmid_bubble%0d: out_valid=%b, want 0", j, a_ov);
            end
         end
      end
   endtask

   task automatic test_n1024();
      int     kc  [3] = '{128, 256, 512};
      longint cre [3] = '{92682, 0, -131072};
      longint cim [3] = '{-92682, -131072, 0};
      longint qre [$];
      longint qim [$];
      int     qtag [$];
      bit     qex [$];
      longint mre, mim, dre, dim;
      int     k, sh, got = 0;
      bit     inv;
      for (int j = 0; j < 45; j++) begin
         if (j < 3) begin
            k = kc[j]; sh = 0; inv = 1'b0;
         end else begin
            k = $urandom_range(0, 1023); sh = $urandom_range(0, 11); inv = 1'($urandom_range(0, 1));
         end
         drv_b(j < 43, k, sh, inv, j % 16);
         if (b_ov) begin
            n_chk++;
            if (qtag.size() == 0) begin
               n_fail++;
               $display("FAIL n1024_extra: unexpected result tag=%0d, want none", b_tago);
            end else begin
               mre = qre.pop_front(); mim = qim.pop_front();
               dre = longint'(b_re) - mre; dim = longint'(b_im) - mim;
               if (dre < 0) dre = -dre;
               if (dim < 0) dim = -dim;
               if (b_tago !== 4'(qtag[0]) || (qex[0] ? (dre != 0 || dim != 0) : (dre > 1 || dim > 1))) begin
                  n_fail++;
                  $display("FAIL n1024_result%0d: re=%0d im=%0d tag=%0d, want %0d %0d %0d",
                           got, b_re, b_im, b_tago, mre, mim, qtag[0]);
               end
               void'(qtag.pop_front()); void'(qex.pop_front());
            end
            got++;
         end
         if (b_vld && b_irdy) begin
            if (j < 3) begin
               mre = cre[j]; mim = cim[j];
            end else begin
               model(1024, 18, k, sh, inv, mre, mim);
            end
            qre.push_back(mre); qim.push_back(mim); qtag.push_back(j % 16); qex.push_back(j < 3);
         end
      end
      n_chk++;
      if (got != 43 || qtag.size() != 0) begin
         n_fail++;
         $display("FAIL n1024_count: delivered=%0d pending=%0d, want 43 0", got, qtag.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      a_vld = 0; a_k = '0; a_sh = '0; a_inv = 0; a_tag = '0; a_ordy = 1;
      b_vld = 0; b_k = '0; b_sh = '0; b_inv = 0; b_tag = '0; b_ordy = 1;
      test_reset();
      test_sweep();
      test_inverse();
      test_shift();
      test_backpressure();
      test_reset_mid();
      test_n1024();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
